ws2812_multi_fader: RTL and testbench

Parametrised multi-channel successor of the single-channel WS2812 colour fader. Holds CHANNELS independent colour values. Once per frame, each value steps toward a per-channel target, and a new random target is drawn whenever a channel arrives. Pulses `trigger` to start a WS2812 frame, then serves values one per `data_request` to the downstream WS2812 serialiser.

---
 rtl/ws2812_multi_fader.sv | 122 ++++++++++++
 tb/tb_ws2812_multi_fader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_multi_fader.sv
// WS2812 multi-channel colour fader: once per frame every channel steps toward its own
// random target, then a trigger pulse starts the serialiser, which pulls values one per request.
module ws2812_multi_fader #(
  parameter int  CHANNELS     = 3,
  parameter int  COLOR_WIDTH  = 8,
  parameter int  STEP         = 1,
  parameter int  FRAME_CYCLES = 65536,
  localparam int IDX_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            random,
  input  logic [1:0]             mode,
  input  logic                   data_request,
  output logic                   trigger,
  output logic [COLOR_WIDTH-1:0] color_now,
  output logic [IDX_W-1:0]       channel
);

  localparam int                     CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(CHANNELS - 1);
  localparam logic [COLOR_WIDTH-1:0] STEP_V   = COLOR_WIDTH'(STEP);

  typedef enum logic [1:0] {IDLE, UPDATE, FIRE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       widx_q;
  logic [IDX_W-1:0]       ridx_q;
  logic [IDX_W-1:0]       rd_idx;
  logic [IDX_W-1:0]       rd_next;
  logic [COLOR_WIDTH-1:0] cur [CHANNELS];
  logic [COLOR_WIDTH-1:0] tgt [CHANNELS];
  logic                   unused_random;

  assign unused_random = ^random;

  // Signed difference in COLOR_WIDTH+1 bits; landing exactly on the target avoids overshoot.
  function automatic logic [COLOR_WIDTH-1:0] step_toward(input logic [COLOR_WIDTH-1:0] c,
                                                          input logic [COLOR_WIDTH-1:0] t);
    logic signed [COLOR_WIDTH:0] diff;
    logic signed [COLOR_WIDTH:0] neg;
    logic [COLOR_WIDTH-1:0]      mag;
    diff = $signed({1'b0, t}) - $signed({1'b0, c});
    neg  = -diff;
    mag  = diff[COLOR_WIDTH] ? neg[COLOR_WIDTH-1:0] : diff[COLOR_WIDTH-1:0];
    if (mag <= STEP_V)
      return t;
    else if (diff[COLOR_WIDTH])
      return c - STEP_V;
    else
      return c + STEP_V;
  endfunction

  function automatic logic [COLOR_WIDTH-1:0] sat_dec(input logic [COLOR_WIDTH-1:0] c);
    return (c > STEP_V) ? c - STEP_V : '0;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q == CNT_LAST) state_d = UPDATE;
      UPDATE:  if (widx_q == IDX_LAST) state_d = FIRE;
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request landing on FIRE is served from index 0, as FIRE rewinds the read pointer.
  always_comb begin
    rd_idx  = (state_q == FIRE) ? '0 : ridx_q;
    rd_next = (rd_idx == IDX_LAST) ? '0 : rd_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      widx_q    <= '0;
      ridx_q    <= '0;
      trigger   <= 1'b0;
      color_now <= '0;
      channel   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      trigger <= (state_q == FIRE);
      cnt_q   <= (state_q == IDLE && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
      widx_q  <= (state_q == UPDATE && widx_q != IDX_LAST) ? widx_q + 1'b1 : '0;

      if (state_q == UPDATE) begin
        if (mode == 2'd2) begin
          tgt[widx_q] <= '0;
          cur[widx_q] <= sat_dec(cur[widx_q]);
        end else if (mode != 2'd1) begin
          if (cur[widx_q] == tgt[widx_q])
            tgt[widx_q] <= random[COLOR_WIDTH-1:0];
          else
            cur[widx_q] <= step_toward(cur[widx_q], tgt[widx_q]);
        end
      end

      if (data_request) begin
        color_now <= cur[rd_idx];
        channel   <= rd_idx;
        ridx_q    <= rd_next;
      end else if (state_q == FIRE) begin
        ridx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_multi_fader.sv
// Bench for ws2812_multi_fader: frame-level reference model checked every cycle,
// a table of per-frame expected colours, and hand sequences for reset and FIRE corners.
`timescale 1ns/1ps
module tb_ws2812_multi_fader;
  localparam int CH  = 3;
  localparam int W   = 8;
  localparam int ST  = 4;
  localparam int FC  = 16;
  localparam int PER = FC + CH + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] random = 16'h0;
  logic [1:0]  mode = 2'd0;
  logic        data_request = 1'b0;
  logic        trigger;
  logic [7:0]  color_now;
  logic [1:0]  channel;

  ws2812_multi_fader #(.CHANNELS(CH), .COLOR_WIDTH(W), .STEP(ST), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .random(random), .mode(mode), .data_request(data_request),
    .trigger(trigger), .color_now(color_now), .channel(channel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycle index since reset release drives the frame schedule.
  int m_cur [CH];
  int m_tgt [CH];
  int m_ridx, m_color, m_chan, m_trig, cyc;

  typedef struct {
    bit          rst_first;
    logic [1:0]  md;
    logic [15:0] rnd;
    logic [7:0]  exp_val;
  } row_t;
  row_t rows [22];

  int trig_seen [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
    m_ridx = 0; m_color = 0; m_chan = 0; m_trig = 0; cyc = 0;
  endtask

  task automatic model_step();
    int ph, idx, c, d;
    ph = cyc % PER;
    m_trig = (ph == PER - 1) ? 1 : 0;
    if (data_request) begin
      idx     = (ph == PER - 1) ? 0 : m_ridx;
      m_color = m_cur[idx];
      m_chan  = idx;
      m_ridx  = (idx + 1) % CH;
    end else if (ph == PER - 1) begin
      m_ridx = 0;
    end
    if (ph >= FC && ph < FC + CH) begin
      c = ph - FC;
      if (mode == 2'd2) begin
        m_tgt[c] = 0;
        m_cur[c] = (m_cur[c] > ST) ? m_cur[c] - ST : 0;
      end else if (mode != 2'd1) begin
        d = m_tgt[c] - m_cur[c];
        if (d == 0)
          m_tgt[c] = random & ((1 << W) - 1);
        else if (d <= ST && d >= -ST)
          m_cur[c] = m_tgt[c];
        else
          m_cur[c] = m_cur[c] + ((d > 0) ? ST : -ST);
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("trigger", trigger, m_trig);
    chk("color_now", color_now, m_color);
    chk("channel", channel, m_chan);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    data_request = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_trigger", trigger, 0);
    chk("rst_color", color_now, 0);
    chk("rst_channel", channel, 0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int got, first, r_mode;

    rows[0]  = '{1'b1, 2'd0, 16'h0010, 8'h00};
    rows[1]  = '{1'b0, 2'd0, 16'h0010, 8'h04};
    rows[2]  = '{1'b0, 2'd0, 16'h0010, 8'h08};
    rows[3]  = '{1'b0, 2'd0, 16'h0010, 8'h0C};
    rows[4]  = '{1'b0, 2'd0, 16'h0010, 8'h10};
    rows[5]  = '{1'b0, 2'd0, 16'h0010, 8'h10};
    rows[6]  = '{1'b0, 2'd1, 16'h0055, 8'h10};
    rows[7]  = '{1'b0, 2'd1, 16'h0055, 8'h10};
    rows[8]  = '{1'b0, 2'd1, 16'h0055, 8'h10};
    rows[9]  = '{1'b0, 2'd1, 16'h0055, 8'h10};
    rows[10] = '{1'b0, 2'd1, 16'h0055, 8'h10};
    rows[11] = '{1'b1, 2'd0, 16'h0002, 8'h00};
    rows[12] = '{1'b0, 2'd0, 16'h0002, 8'h02};
    rows[13] = '{1'b0, 2'd0, 16'h00FE, 8'h02};
    rows[14] = '{1'b0, 2'd0, 16'h00FE, 8'h06};
    rows[15] = '{1'b0, 2'd0, 16'h00FE, 8'h0A};
    rows[16] = '{1'b0, 2'd2, 16'h00FE, 8'h06};
    rows[17] = '{1'b0, 2'd2, 16'h00FE, 8'h02};
    rows[18] = '{1'b0, 2'd2, 16'h00FE, 8'h00};
    rows[19] = '{1'b0, 2'd2, 16'h00FE, 8'h00};
    rows[20] = '{1'b0, 2'd0, 16'h00FE, 8'h00};
    rows[21] = '{1'b0, 2'd0, 16'h00FE, 8'h04};

    model_reset();

    // Reset and frame period with no reads.
    apply_reset();
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      if (trigger) trig_seen.push_back(i);
    end
    chk("period_count", trig_seen.size(), 3);
    if (trig_seen.size() == 3) begin
      chk("period_t0", trig_seen[0], 19);
      chk("period_t1", trig_seen[1], 39);
      chk("period_t2", trig_seen[2], 59);
    end

    // Per-frame colour table, four reads two cycles apart after each trigger.
    for (int r = 0; r < 22; r++) begin
      if (rows[r].rst_first) apply_reset();
      mode   = rows[r].md;
      random = rows[r].rnd;
      got = 0;
      for (int i = 0; i < PER + 2 && got == 0; i++) begin
        tick();
        if (trigger) got = 1;
      end
      chk("row_trigger", got, 1);
      for (int k = 0; k < 4; k++) begin
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        chk("row_channel", channel, k % CH);
        chk("row_color", color_now, rows[r].exp_val);
        tick();
      end
      if (r == 10) begin
        // Async reset in the middle of UPDATE, between clock edges.
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        chk("pre_rst_channel", channel, 1);
        chk("pre_rst_color", color_now, 8'h10);
        for (int i = 0; i < PER; i++) begin
          tick();
          if (((cyc - 1) % PER) == FC) break;
        end
        chk("mid_update_phase", (cyc - 1) % PER, FC);
        #1 rst = 1'b0;
        #2;
        chk("async_trigger", trigger, 0);
        chk("async_color", color_now, 0);
        chk("async_channel", channel, 0);
        model_reset();
        #1 rst = 1'b1;
        first = -1;
        for (int i = 0; i < PER; i++) begin
          tick();
          if (trigger && first < 0) first = i;
        end
        chk("post_rst_first_trigger", first, FC + CH);

        // Request coincident with FIRE while the read pointer sits at 1.
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        chk("pre_fire_channel", channel, 0);
        for (int i = 0; i < PER; i++) begin
          tick();
          if (((cyc - 1) % PER) == PER - 2) break;
        end
        data_request = 1'b1;
        tick();
        chk("fire_trigger", trigger, 1);
        chk("fire_channel", channel, 0);
        tick();
        data_request = 1'b0;
        chk("after_fire_channel", channel, 1);
      end
    end

    // Randomized stimulus against the reference model.
    apply_reset();
    for (int i = 0; i < 1200; i++) begin
      r_mode = $urandom_range(0, 19);
      if (r_mode < 12)      mode = 2'd0;
      else if (r_mode < 14) mode = 2'd3;
      else if (r_mode < 17) mode = 2'd2;
      else                  mode = 2'd1;
      random = 16'($urandom);
      data_request = ($urandom_range(0, 2) == 0);
      tick();
    end
    data_request = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
